// File: rtl/mbist_repair_mux_if.sv
// mbist_repair_mux_if: BIST, functional and memory-side signals of the repair mux
interface mbist_repair_mux_if #(
  parameter int BIST_ADDR_WD = 9,
  parameter int BIST_DATA_WD = 32,
  parameter int NUM_SPARE    = 4
);
  localparam int CW = $clog2(NUM_SPARE + 1);
  localparam int MW = BIST_DATA_WD / 8;
  logic                    bist_en;
  logic                    bist_ready;
  logic [BIST_ADDR_WD-1:0] bist_addr;
  logic [BIST_ADDR_WD-1:0] bist_error_addr;
  logic [BIST_DATA_WD-1:0] bist_wdata;
  logic                    bist_wr;
  logic                    bist_rd;
  logic                    bist_error;
  logic                    repair_clr;
  logic                    bist_correct;
  logic                    bist_repair_fail;
  logic [CW-1:0]           repair_cnt;
  logic                    func_busy;
  logic                    func_cen_a;
  logic [BIST_ADDR_WD-1:0] func_addr_a;
  logic [BIST_DATA_WD-1:0] func_dout_a;
  logic                    func_cen_b;
  logic                    func_web_b;
  logic [MW-1:0]           func_mask_b;
  logic [BIST_ADDR_WD-1:0] func_addr_b;
  logic [BIST_DATA_WD-1:0] func_din_b;
  logic                    mem_cen_a;
  logic [BIST_ADDR_WD-1:0] mem_addr_a;
  logic [BIST_DATA_WD-1:0] mem_dout_a;
  logic                    mem_cen_b;
  logic                    mem_web_b;
  logic [MW-1:0]           mem_mask_b;
  logic [BIST_ADDR_WD-1:0] mem_addr_b;
  logic [BIST_DATA_WD-1:0] mem_din_b;
  modport slave (
    input  bist_en, bist_addr, bist_error_addr, bist_wdata, bist_wr, bist_rd, bist_error, repair_clr,
           func_cen_a, func_addr_a, func_cen_b, func_web_b, func_mask_b, func_addr_b, func_din_b, mem_dout_a,
    output bist_ready, bist_correct, bist_repair_fail, repair_cnt, func_busy, func_dout_a,
           mem_cen_a, mem_addr_a, mem_cen_b, mem_web_b, mem_mask_b, mem_addr_b, mem_din_b
  );
  modport master (
    output bist_en, bist_addr, bist_error_addr, bist_wdata, bist_wr, bist_rd, bist_error, repair_clr,
           func_cen_a, func_addr_a, func_cen_b, func_web_b, func_mask_b, func_addr_b, func_din_b, mem_dout_a,
    input  bist_ready, bist_correct, bist_repair_fail, repair_cnt, func_busy, func_dout_a,
           mem_cen_a, mem_addr_a, mem_cen_b, mem_web_b, mem_mask_b, mem_addr_b, mem_din_b
  );
endinterface

// File: rtl/mbist_repair_mux.sv
// mbist_repair_mux: functional/BIST memory port arbitration with spare-row repair remapping
module mbist_repair_mux #(
  parameter int BIST_ADDR_WD = 9,
  parameter int BIST_DATA_WD = 32,
  parameter int NUM_SPARE    = 4
) (
  input logic clk,
  input logic rst_n,
  mbist_repair_mux_if.slave bus
);
  localparam int CW = $clog2(NUM_SPARE + 1);
  localparam logic [BIST_ADDR_WD-1:0] SPARE_BASE = {BIST_ADDR_WD{1'b1}} - BIST_ADDR_WD'(NUM_SPARE - 1);
  typedef enum logic [1:0] {FUNC, DRAIN_B, BIST, DRAIN_F} state_t;
  state_t state, state_nx;
  logic idle, idle_q, in_bist, drain;
  logic [NUM_SPARE-1:0] valid, we;
  logic [BIST_ADDR_WD-1:0] fail_addr [NUM_SPARE];
  logic [CW-1:0] cnt, cnt_nx;
  logic fail, fail_nx, correct, err_hit, alloc, full;
  logic [BIST_ADDR_WD-1:0] pre_a, pre_b, ra, rb;
  assign idle = bus.func_cen_a && bus.func_cen_b;
  assign in_bist = state == BIST;
  assign drain = state == DRAIN_B || state == DRAIN_F;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state  <= FUNC;
      idle_q <= 1'b0;
    end else begin
      state  <= state_nx;
      idle_q <= state == DRAIN_B && idle;
    end
  // idle_q marks the first of the two idle cycles needed before handing the ports over
  always_comb begin
    state_nx = state;
    case (state)
      FUNC:    state_nx = bus.bist_en ? DRAIN_B : FUNC;
      DRAIN_B: state_nx = !bus.bist_en ? FUNC : (idle && idle_q) ? BIST : DRAIN_B;
      BIST:    state_nx = bus.bist_en ? BIST : DRAIN_F;
      default: state_nx = FUNC;
    endcase
  end
  assign bus.bist_ready  = in_bist;
  assign bus.func_busy   = state != FUNC;
  assign bus.mem_cen_a   = drain || (in_bist ? !bus.bist_rd : bus.func_cen_a);
  assign bus.mem_cen_b   = drain || (in_bist ? !bus.bist_wr : bus.func_cen_b);
  assign bus.mem_web_b   = in_bist ? !bus.bist_wr : bus.func_web_b;
  assign bus.mem_mask_b  = in_bist ? '1 : bus.func_mask_b;
  assign bus.mem_din_b   = in_bist ? bus.bist_wdata : bus.func_din_b;
  assign bus.func_dout_a = bus.mem_dout_a;
  assign pre_a = in_bist ? bus.bist_addr : bus.func_addr_a;
  assign pre_b = in_bist ? bus.bist_addr : bus.func_addr_b;
  always_comb begin
    ra = pre_a;
    rb = pre_b;
    for (int i = 0; i < NUM_SPARE; i++) begin
      ra = valid[i] && fail_addr[i] == pre_a ? SPARE_BASE + BIST_ADDR_WD'(i) : ra;
      rb = valid[i] && fail_addr[i] == pre_b ? SPARE_BASE + BIST_ADDR_WD'(i) : rb;
    end
  end
  assign bus.mem_addr_a = ra;
  assign bus.mem_addr_b = rb;
  // repair_clr suppresses allocation so a simultaneous error cannot survive the clear
  always_comb begin
    err_hit = 1'b0;
    for (int i = 0; i < NUM_SPARE; i++)
      err_hit = err_hit || (valid[i] && fail_addr[i] == bus.bist_error_addr);
    full  = cnt == CW'(NUM_SPARE);
    alloc = in_bist && bus.bist_error && !err_hit && !bus.repair_clr;
    we    = '0;
    for (int i = 0; i < NUM_SPARE; i++)
      we[i] = alloc && !full && cnt == CW'(i);
    cnt_nx  = bus.repair_clr ? '0 : cnt + CW'(alloc && !full);
    fail_nx = !bus.repair_clr && (fail || (alloc && full));
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      valid     <= '0;
      fail_addr <= '{default: '0};
      cnt       <= '0;
      fail      <= 1'b0;
      correct   <= 1'b0;
    end else begin
      valid   <= (bus.repair_clr ? '0 : valid) | we;
      cnt     <= cnt_nx;
      fail    <= fail_nx;
      correct <= |cnt_nx && !fail_nx;
      for (int i = 0; i < NUM_SPARE; i++)
        if (we[i]) fail_addr[i] <= bus.bist_error_addr;
    end
  assign bus.repair_cnt       = cnt;
  assign bus.bist_repair_fail = fail;
  assign bus.bist_correct     = correct;
endmodule

// File: tb/tb_mbist_repair_mux.sv
// tb_mbist_repair_mux: scenario tasks with a queue scoreboard for the repair mux
module tb_mbist_repair_mux;
  localparam int AW = 9, DW = 32, NS = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_checks = 0, n_fail = 0;
  logic [31:0] sb[$];
  mbist_repair_mux_if #(.BIST_ADDR_WD(AW), .BIST_DATA_WD(DW), .NUM_SPARE(NS)) bus();
  mbist_repair_mux #(.BIST_ADDR_WD(AW), .BIST_DATA_WD(DW), .NUM_SPARE(NS)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(negedge clk);
  endtask
  task automatic init_inputs;
    bus.bist_en = 0; bus.bist_addr = '0; bus.bist_error_addr = '0; bus.bist_wdata = '0;
    bus.bist_wr = 0; bus.bist_rd = 0; bus.bist_error = 0; bus.repair_clr = 0;
    bus.func_cen_a = 1; bus.func_addr_a = '0; bus.func_cen_b = 1; bus.func_web_b = 1;
    bus.func_mask_b = '0; bus.func_addr_b = '0; bus.func_din_b = '0; bus.mem_dout_a = '0;
  endtask
  task automatic enter_bist;
    int k = 0;
    bus.func_cen_a = 1; bus.func_cen_b = 1; bus.bist_en = 1;
    while (k < 10 && bus.bist_ready !== 1'b1) begin tick; k++; end
    n_checks++;
    if (bus.bist_ready !== 1'b1) begin n_fail++; $display("FAIL enter_bist_timeout: bist_ready=%b want 1", bus.bist_ready); end
  endtask
  task automatic test_reset;
    rst_n = 0; bus.bist_en = 1; bus.bist_error = 1; bus.bist_error_addr = 9'h005;
    bus.func_cen_a = 0; bus.func_cen_b = 0; bus.func_addr_a = 9'h005; bus.func_addr_b = 9'h1A3; bus.func_mask_b = 4'hA;
    tick; tick;
    n_checks++; if (bus.bist_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", bus.bist_ready); end
    n_checks++; if (bus.func_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.func_busy); end
    n_checks++; if (bus.repair_cnt !== 3'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", bus.repair_cnt); end
    n_checks++; if (bus.bist_correct !== 1'b0 || bus.bist_repair_fail !== 1'b0) begin n_fail++; $display("FAIL reset_flags: correct=%b fail=%b want 0 0", bus.bist_correct, bus.bist_repair_fail); end
    n_checks++; if (bus.mem_addr_a !== 9'h005 || bus.mem_addr_b !== 9'h1A3) begin n_fail++; $display("FAIL reset_addr: a=%h b=%h want 005 1a3", bus.mem_addr_a, bus.mem_addr_b); end
    n_checks++; if (bus.mem_cen_a !== 1'b0 || bus.mem_cen_b !== 1'b0 || bus.mem_mask_b !== 4'hA) begin n_fail++; $display("FAIL reset_ctrl: cen_a=%b cen_b=%b mask=%h want 0 0 a", bus.mem_cen_a, bus.mem_cen_b, bus.mem_mask_b); end
    init_inputs; rst_n = 1; tick;
  endtask
  task automatic test_func_path;
    logic [31:0] e;
    for (int i = 0; i < 4; i++) begin
      bus.func_addr_a = AW'($urandom); bus.func_addr_b = AW'($urandom); bus.func_din_b = $urandom;
      bus.func_mask_b = 4'($urandom); bus.func_cen_a = 1'($urandom); bus.func_web_b = 1'($urandom); bus.mem_dout_a = $urandom;
      sb.push_back(32'(bus.func_addr_a)); sb.push_back(32'(bus.func_addr_b)); sb.push_back(bus.func_din_b);
      sb.push_back({27'd0, bus.func_cen_a, bus.func_mask_b}); sb.push_back(bus.mem_dout_a);
      #1;
      e = sb.pop_front(); n_checks++; if (32'(bus.mem_addr_a) !== e) begin n_fail++; $display("FAIL func_addr_a: got %h want %h", bus.mem_addr_a, e); end
      e = sb.pop_front(); n_checks++; if (32'(bus.mem_addr_b) !== e) begin n_fail++; $display("FAIL func_addr_b: got %h want %h", bus.mem_addr_b, e); end
      e = sb.pop_front(); n_checks++; if (bus.mem_din_b !== e) begin n_fail++; $display("FAIL func_din_b: got %h want %h", bus.mem_din_b, e); end
      e = sb.pop_front(); n_checks++; if ({27'd0, bus.mem_cen_a, bus.mem_mask_b} !== e) begin n_fail++; $display("FAIL func_cen_mask: got %b/%h want %h", bus.mem_cen_a, bus.mem_mask_b, e); end
      e = sb.pop_front(); n_checks++; if (bus.func_dout_a !== e) begin n_fail++; $display("FAIL func_dout_a: got %h want %h", bus.func_dout_a, e); end
      tick;
    end
    init_inputs; tick;
  endtask
  task automatic test_abort;
    bus.func_cen_b = 0; bus.bist_en = 1; tick;
    n_checks++; if (bus.func_busy !== 1'b1) begin n_fail++; $display("FAIL abort_busy: got %b want 1", bus.func_busy); end
    bus.bist_en = 0; tick;
    n_checks++; if (bus.func_busy !== 1'b0 || bus.bist_ready !== 1'b0) begin n_fail++; $display("FAIL abort_return: busy=%b ready=%b want 0 0", bus.func_busy, bus.bist_ready); end
    bus.func_cen_b = 1; tick;
  endtask
  task automatic test_handover;
    bus.func_cen_a = 1; bus.func_cen_b = 0; bus.bist_en = 1; tick;
    n_checks++; if (bus.func_busy !== 1'b1 || bus.mem_cen_a !== 1'b1 || bus.mem_cen_b !== 1'b1) begin n_fail++; $display("FAIL drain_force: busy=%b cen_a=%b cen_b=%b want 1 1 1", bus.func_busy, bus.mem_cen_a, bus.mem_cen_b); end
    repeat (3) tick;
    n_checks++; if (bus.bist_ready !== 1'b0 || bus.func_busy !== 1'b1) begin n_fail++; $display("FAIL drain_hold: ready=%b busy=%b want 0 1", bus.bist_ready, bus.func_busy); end
    bus.func_cen_b = 1; tick;
    n_checks++; if (bus.bist_ready !== 1'b0) begin n_fail++; $display("FAIL handover_early: ready=%b want 0", bus.bist_ready); end
    tick;
    n_checks++; if (bus.bist_ready !== 1'b1) begin n_fail++; $display("FAIL handover_ready: ready=%b want 1", bus.bist_ready); end
  endtask
  task automatic test_bist_path;
    bus.func_addr_a = 9'h033; bus.func_addr_b = 9'h044; bus.func_mask_b = 4'h0; bus.func_din_b = '0;
    bus.bist_rd = 1; bus.bist_wr = 1; bus.bist_addr = 9'h0AB; bus.bist_wdata = 32'hDEADBEEF; #1;
    n_checks++; if (bus.mem_cen_a !== 1'b0 || bus.mem_cen_b !== 1'b0 || bus.mem_web_b !== 1'b0) begin n_fail++; $display("FAIL bist_strobes: cen_a=%b cen_b=%b web=%b want 0 0 0", bus.mem_cen_a, bus.mem_cen_b, bus.mem_web_b); end
    n_checks++; if (bus.mem_mask_b !== 4'hF || bus.mem_din_b !== 32'hDEADBEEF) begin n_fail++; $display("FAIL bist_data: mask=%h din=%h want f deadbeef", bus.mem_mask_b, bus.mem_din_b); end
    n_checks++; if (bus.mem_addr_a !== 9'h0AB || bus.mem_addr_b !== 9'h0AB) begin n_fail++; $display("FAIL bist_addr: a=%h b=%h want 0ab 0ab", bus.mem_addr_a, bus.mem_addr_b); end
    bus.bist_wr = 0; #1;
    n_checks++; if (bus.mem_cen_a !== 1'b0 || bus.mem_cen_b !== 1'b1 || bus.mem_web_b !== 1'b1) begin n_fail++; $display("FAIL bist_rd_only: cen_a=%b cen_b=%b web=%b want 0 1 1", bus.mem_cen_a, bus.mem_cen_b, bus.mem_web_b); end
    bus.bist_rd = 0; tick;
  endtask
  task automatic test_repair;
    logic [31:0] e;
    bus.bist_addr = 9'h005; bus.bist_error_addr = 9'h005; bus.bist_error = 1; #1;
    n_checks++; if (bus.mem_addr_a !== 9'h005) begin n_fail++; $display("FAIL repair_latency: a=%h want 005", bus.mem_addr_a); end
    sb.push_back(32'd1); tick; bus.bist_error = 0;
    e = sb.pop_front(); n_checks++; if (32'(bus.repair_cnt) !== e) begin n_fail++; $display("FAIL repair_cnt: got %0d want %0d", bus.repair_cnt, e); end
    #1;
    n_checks++; if (bus.mem_addr_a !== 9'h1FC || bus.mem_addr_b !== 9'h1FC) begin n_fail++; $display("FAIL repair_remap: a=%h b=%h want 1fc 1fc", bus.mem_addr_a, bus.mem_addr_b); end
    tick;
    n_checks++; if (bus.bist_correct !== 1'b1) begin n_fail++; $display("FAIL repair_correct: got %b want 1", bus.bist_correct); end
  endtask
  task automatic test_persistence;
    bus.func_cen_a = 0; bus.func_cen_b = 0; bus.func_addr_a = 9'h005; bus.func_addr_b = 9'h005; bus.bist_en = 0; tick;
    n_checks++; if (bus.bist_ready !== 1'b0 || bus.func_busy !== 1'b1 || bus.mem_cen_a !== 1'b1 || bus.mem_cen_b !== 1'b1) begin n_fail++; $display("FAIL drain_f: ready=%b busy=%b cen_a=%b cen_b=%b want 0 1 1 1", bus.bist_ready, bus.func_busy, bus.mem_cen_a, bus.mem_cen_b); end
    tick;
    n_checks++; if (bus.func_busy !== 1'b0 || bus.mem_cen_b !== 1'b0) begin n_fail++; $display("FAIL back_to_func: busy=%b cen_b=%b want 0 0", bus.func_busy, bus.mem_cen_b); end
    n_checks++; if (bus.mem_addr_b !== 9'h1FC || bus.mem_addr_a !== 9'h1FC) begin n_fail++; $display("FAIL persist_remap: a=%h b=%h want 1fc 1fc", bus.mem_addr_a, bus.mem_addr_b); end
    bus.func_addr_b = 9'h006; #1;
    n_checks++; if (bus.mem_addr_b !== 9'h006) begin n_fail++; $display("FAIL func_no_remap: b=%h want 006", bus.mem_addr_b); end
    bus.func_cen_a = 1; bus.func_cen_b = 1;
  endtask
  task automatic test_clear_priority;
    enter_bist;
    bus.bist_error = 1; bus.bist_error_addr = 9'h020; bus.repair_clr = 1; tick;
    bus.bist_error = 0; bus.repair_clr = 0;
    n_checks++; if (bus.repair_cnt !== 3'd0 || bus.bist_repair_fail !== 1'b0) begin n_fail++; $display("FAIL clear_cnt: cnt=%0d fail=%b want 0 0", bus.repair_cnt, bus.bist_repair_fail); end
    bus.bist_addr = 9'h020; #1;
    n_checks++; if (bus.mem_addr_a !== 9'h020) begin n_fail++; $display("FAIL clear_new: a=%h want 020", bus.mem_addr_a); end
    bus.bist_addr = 9'h005; #1;
    n_checks++; if (bus.mem_addr_b !== 9'h005) begin n_fail++; $display("FAIL clear_old: b=%h want 005", bus.mem_addr_b); end
    tick;
    n_checks++; if (bus.bist_correct !== 1'b0) begin n_fail++; $display("FAIL clear_correct: got %b want 0", bus.bist_correct); end
  endtask
  task automatic test_overflow;
    logic [AW-1:0] errs[6] = '{9'h010, 9'h010, 9'h011, 9'h012, 9'h013, 9'h014};
    logic [AW-1:0] tbl[$];
    logic mfail = 0, found;
    logic [31:0] e, ea;
    for (int i = 0; i < 6; i++) begin
      found = 0;
      foreach (tbl[j]) if (tbl[j] == errs[i]) found = 1;
      if (!found && tbl.size() < NS) tbl.push_back(errs[i]);
      else if (!found) mfail = 1;
      sb.push_back(32'(tbl.size())); sb.push_back(32'(mfail));
      bus.bist_error = 1; bus.bist_error_addr = errs[i]; tick;
      e = sb.pop_front(); n_checks++; if (32'(bus.repair_cnt) !== e) begin n_fail++; $display("FAIL ovf_cnt[%0d]: got %0d want %0d", i, bus.repair_cnt, e); end
      e = sb.pop_front(); n_checks++; if (32'(bus.bist_repair_fail) !== e) begin n_fail++; $display("FAIL ovf_fail[%0d]: got %b want %0d", i, bus.bist_repair_fail, e); end
    end
    bus.bist_error = 0; tick;
    n_checks++; if (bus.bist_correct !== ((tbl.size() != 0) && !mfail)) begin n_fail++; $display("FAIL ovf_correct: got %b want %b", bus.bist_correct, (tbl.size() != 0) && !mfail); end
    for (int i = 1; i < 6; i++) begin
      ea = 32'(errs[i]);
      foreach (tbl[j]) if (tbl[j] == errs[i]) ea = 32'h200 - NS + j;
      sb.push_back(ea); sb.push_back(ea);
      bus.bist_addr = errs[i]; #1;
      e = sb.pop_front(); n_checks++; if (32'(bus.mem_addr_a) !== e) begin n_fail++; $display("FAIL ovf_remap_a %h: got %h want %h", errs[i], bus.mem_addr_a, e); end
      e = sb.pop_front(); n_checks++; if (32'(bus.mem_addr_b) !== e) begin n_fail++; $display("FAIL ovf_remap_b %h: got %h want %h", errs[i], bus.mem_addr_b, e); end
    end
    tick;
  endtask
  task automatic test_ignore_outside;
    bus.bist_en = 0; tick; tick;
    bus.repair_clr = 1; tick; bus.repair_clr = 0;
    n_checks++; if (bus.repair_cnt !== 3'd0 || bus.bist_repair_fail !== 1'b0) begin n_fail++; $display("FAIL func_clear: cnt=%0d fail=%b want 0 0", bus.repair_cnt, bus.bist_repair_fail); end
    bus.bist_error = 1; bus.bist_error_addr = 9'h030; tick; tick; bus.bist_error = 0;
    n_checks++; if (bus.repair_cnt !== 3'd0) begin n_fail++; $display("FAIL ignore_cnt: got %0d want 0", bus.repair_cnt); end
    bus.func_addr_a = 9'h030; #1;
    n_checks++; if (bus.mem_addr_a !== 9'h030) begin n_fail++; $display("FAIL ignore_remap: a=%h want 030", bus.mem_addr_a); end
    tick;
  endtask
  task automatic test_async_reset;
    enter_bist;
    bus.bist_error = 1; bus.bist_error_addr = 9'h042; tick; bus.bist_error = 0;
    n_checks++; if (bus.repair_cnt !== 3'd1) begin n_fail++; $display("FAIL pre_reset_cnt: got %0d want 1", bus.repair_cnt); end
    #1 rst_n = 0; #1;
    n_checks++; if (bus.bist_ready !== 1'b0 || bus.repair_cnt !== 3'd0 || bus.func_busy !== 1'b0) begin n_fail++; $display("FAIL async_reset: ready=%b cnt=%0d busy=%b want 0 0 0", bus.bist_ready, bus.repair_cnt, bus.func_busy); end
    tick; bus.bist_en = 0; rst_n = 1; tick;
  endtask
  initial begin
    init_inputs;
    test_reset;
    test_func_path;
    test_abort;
    test_handover;
    test_bist_path;
    test_repair;
    test_persistence;
    test_clear_priority;
    test_overflow;
    test_ignore_outside;
    test_async_reset;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
